disp_map_sad: RTL and testbench

Parametrised stereo disparity engine, successor to the fixed 640x480 / 64-window calculator. For each left-image pixel it computes a horizontal 1-D sum-of-absolute-differences (SAD) against right-image pixels over a run-time selectable window and disparity range. It streams one packed result word per pixel into the downstream result FIFO. It reads the left (reference) and right frame BRAMs through their read ports and sits between those BRAMs and the disparity FIFO.

---
 rtl/disp_map_sad_if.sv | 32 +++
 rtl/disp_map_sad.sv | 220 ++++++++++++++++++++++
 tb/tb_disp_map_sad.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_map_sad_if.sv
// Frame-BRAM read ports and result-FIFO write port of the disparity engine.
interface disp_map_sad_if;
  logic        en_ref;
  logic [3:0]  we_ref;
  logic [31:0] addr_ref;
  logic [31:0] dout_ref;
  logic        enb;
  logic [3:0]  web;
  logic [31:0] addrb;
  logic [31:0] doutb;
  logic [31:0] din_fifo;
  logic        wr_en_fifo;
  logic        busy;

  modport master (
    output en_ref, we_ref, addr_ref,
    input  dout_ref,
    output enb, web, addrb,
    input  doutb,
    output din_fifo, wr_en_fifo,
    input  busy
  );

  modport slave (
    input  en_ref, we_ref, addr_ref,
    output dout_ref,
    input  enb, web, addrb,
    output doutb,
    input  din_fifo, wr_en_fifo,
    output busy
  );
endinterface

// File: rtl/disp_map_sad.sv
// Stereo disparity engine: 1-D horizontal SAD per left pixel over a run-time
// window and disparity range, one packed result word per pixel to the FIFO.
module disp_map_sad #(
  parameter int MAX_DISP = 64,
  parameter int HRES     = 640,
  parameter int VRES     = 480,
  parameter int PIX_W    = 8
) (
  input  logic          clkb,
  input  logic          reset,
  input  logic          go,
  input  logic [2:0]    window,
  input  logic [7:0]    num_disp,
  input  logic [15:0]   thresh,
  output logic          done,
  disp_map_sad_if.master bus
);
  localparam int XW    = $clog2(HRES + 1);
  localparam int YW    = $clog2(VRES + 1);
  localparam int SAD_W = PIX_W + 4;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, COMPARE, EMIT, WAIT, DONE} state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [8:0]        d;
  logic [8:0]        nd_r;
  logic [3:0]        tap;
  logic [2:0]        h_r;
  logic [15:0]       thr_r;
  logic              en_r;
  logic [31:0]       addr_ref_r;
  logic [31:0]       addrb_r;
  logic [31:0]       din_r;
  logic              wr_pend;
  logic              vld_p1;
  logic              first_p1;
  logic [SAD_W-1:0]  sad;
  logic [SAD_W-1:0]  best_sad;
  logic [7:0]        best_d;
  logic              upd;
  logic [SAD_W-1:0]  nb_sad;
  logic [7:0]        nb_d;
  logic              last_x;
  logic              eof_w;
  int                tap_x_i;
  int                nxt_x_i;
  int                nxt_y_i;
  logic              unused_hi;

  function automatic int clamp_x(input int v);
    if (v < 0) return 0;
    else if (v > HRES - 1) return HRES - 1;
    else return v;
  endfunction

  function automatic logic [31:0] pix_addr(input int yy, input int xx);
    return 32'((yy * HRES + clamp_x(xx)) * 4);
  endfunction

  function automatic logic [8:0] clamp_nd(input logic [7:0] n);
    if (n == 8'd0) return 9'd1;
    else if (int'(n) > MAX_DISP) return 9'(MAX_DISP);
    else return {1'b0, n};
  endfunction

  function automatic logic [SAD_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return (diff < 0) ? SAD_W'(-diff) : SAD_W'(diff);
  endfunction

  function automatic logic [13:0] sat14(input logic [SAD_W-1:0] s);
    if (32'(s) > 32'h3FFF) return 14'h3FFF;
    else return 14'(s);
  endfunction

  function automatic logic [31:0] build_word(input logic eof, input logic [SAD_W-1:0] s,
                                             input logic [7:0] bd, input logic [15:0] thr);
    return {eof, (32'(s) > 32'(thr)), sat14(s), 8'h00, bd};
  endfunction

  assign unused_hi = ^{bus.dout_ref[31:PIX_W], bus.doutb[31:PIX_W]};

  assign last_x = (x == XW'(HRES - 1));
  assign eof_w  = last_x && (y == YW'(VRES - 1));

  // Best-so-far selection and next-address coordinates for the FSM
  always_comb begin
    upd     = (d == 9'd0) || (sad < best_sad);
    nb_sad  = upd ? sad : best_sad;
    nb_d    = upd ? d[7:0] : best_d;
    tap_x_i = int'(x) + int'(tap) + 1 - int'(h_r);
    nxt_x_i = last_x ? 0 : int'(x) + 1;
    nxt_y_i = last_x ? int'(y) + 1 : int'(y);
  end

  // Stage 1: read data for the tap issued last cycle arrives; track its validity
  always_ff @(posedge clkb or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p1   <= (state == ISSUE);
      first_p1 <= (state == ISSUE) && (tap == 4'd0);
    end
  end

  // Stage 1 datapath: accumulate |L-R|, restarting on the first tap of a disparity
  always_ff @(posedge clkb) begin
    if (vld_p1)
      sad <= (first_p1 ? '0 : sad) + abs_diff(bus.dout_ref[PIX_W-1:0], bus.doutb[PIX_W-1:0]);
  end

  // Stage 2: keep the lowest SAD seen so far; ties keep the smaller disparity
  always_ff @(posedge clkb) begin
    if (state == COMPARE && upd) begin
      best_sad <= sad;
      best_d   <= d[7:0];
    end
  end

  // Frame sequencing FSM with registered BRAM and FIFO outputs
  always_ff @(posedge clkb or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      d          <= '0;
      tap        <= '0;
      h_r        <= '0;
      nd_r       <= 9'd1;
      thr_r      <= '0;
      done       <= 1'b0;
      en_r       <= 1'b0;
      addr_ref_r <= '0;
      addrb_r    <= '0;
      din_r      <= '0;
      wr_pend    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            h_r        <= window;
            nd_r       <= clamp_nd(num_disp);
            thr_r      <= thresh;
            x          <= '0;
            y          <= '0;
            d          <= '0;
            tap        <= '0;
            done       <= 1'b0;
            en_r       <= 1'b1;
            addr_ref_r <= pix_addr(0, -int'(window));
            addrb_r    <= pix_addr(0, -int'(window));
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (tap == 4'({h_r, 1'b0})) begin
            en_r  <= 1'b0;
            state <= DRAIN;
          end else begin
            tap        <= tap + 4'd1;
            addr_ref_r <= pix_addr(int'(y), tap_x_i);
            addrb_r    <= pix_addr(int'(y), tap_x_i - int'(d));
          end
        end
        DRAIN: state <= COMPARE;
        COMPARE: begin
          if (d < nd_r - 9'd1) begin
            d          <= d + 9'd1;
            tap        <= '0;
            en_r       <= 1'b1;
            addr_ref_r <= pix_addr(int'(y), int'(x) - int'(h_r));
            addrb_r    <= pix_addr(int'(y), int'(x) - int'(h_r) - int'(d) - 1);
            state      <= ISSUE;
          end else begin
            din_r   <= build_word(eof_w, nb_sad, nb_d, thr_r);
            wr_pend <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT, WAIT: begin
          if (!bus.busy) begin
            wr_pend <= 1'b0;
            d       <= '0;
            tap     <= '0;
            x       <= last_x ? '0 : x + XW'(1);
            if (eof_w) begin
              y     <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              if (last_x) y <= y + YW'(1);
              en_r       <= 1'b1;
              addr_ref_r <= pix_addr(nxt_y_i, nxt_x_i - int'(h_r));
              addrb_r    <= pix_addr(nxt_y_i, nxt_x_i - int'(h_r));
              state      <= ISSUE;
            end
          end else begin
            state <= WAIT;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.en_ref     = en_r;
  assign bus.enb        = en_r;
  assign bus.we_ref     = 4'h0;
  assign bus.web        = 4'h0;
  assign bus.addr_ref   = addr_ref_r;
  assign bus.addrb      = addrb_r;
  assign bus.din_fifo   = din_r;
  assign bus.wr_en_fifo = wr_pend & ~bus.busy;
endmodule

// File: tb/tb_disp_map_sad.sv
// Bench for disp_map_sad on a small 8x2 frame with a behavioural SAD model.
module tb_disp_map_sad;
  localparam int HRES = 8, VRES = 2, MAX_DISP = 8, PIX_W = 8, NPIX = HRES * VRES;

  logic        clkb = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [2:0]  window = '0;
  logic [7:0]  num_disp = '0;
  logic [15:0] thresh = '0;
  logic        done;
  logic        busy_force = 1'b0;
  logic        busy_rand = 1'b0;
  logic        rnd_bit = 1'b0;

  int errs = 0, checks = 0, cyc = 0, en_cnt = 0, we_bad = 0, done_cyc = -1;
  logic done_q = 1'b0;
  logic [31:0] wq[$];
  int          wq_cyc[$];
  logic [31:0] lmem [NPIX];
  logic [31:0] rmem [NPIX];
  int          lpix [VRES][HRES];
  int          rpix [VRES][HRES];

  disp_map_sad_if bus();

  disp_map_sad #(.MAX_DISP(MAX_DISP), .HRES(HRES), .VRES(VRES), .PIX_W(PIX_W)) dut (
    .clkb(clkb), .reset(reset), .go(go), .window(window), .num_disp(num_disp),
    .thresh(thresh), .done(done), .bus(bus)
  );

  assign bus.busy = busy_force | (busy_rand & rnd_bit);

  always #5 clkb = ~clkb;

  always @(posedge clkb) cyc <= cyc + 1;

  always @(posedge clkb) begin
    if (bus.en_ref) bus.dout_ref <= lmem[bus.addr_ref[5:2]];
    if (bus.enb)    bus.doutb    <= rmem[bus.addrb[5:2]];
  end

  initial forever begin
    @(posedge clkb); #2;
    rnd_bit = ($urandom_range(0, 3) == 0);
  end

  always @(negedge clkb) begin
    if (bus.wr_en_fifo) begin
      wq.push_back(bus.din_fifo);
      wq_cyc.push_back(cyc);
    end
    if (bus.en_ref) en_cnt <= en_cnt + 1;
    if (bus.en_ref !== bus.enb || bus.we_ref != 4'h0 || bus.web != 4'h0) we_bad <= we_bad + 1;
    if (done && !done_q) done_cyc <= cyc;
    done_q <= done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int cl(input int v);
    return (v < 0) ? 0 : (v > HRES - 1) ? HRES - 1 : v;
  endfunction

  function automatic int eff_nd(input int nd);
    return (nd == 0) ? 1 : (nd > MAX_DISP) ? MAX_DISP : nd;
  endfunction

  // Expected result word straight from the SAD definition
  function automatic logic [31:0] model_word(input int x, input int y, input int h,
                                             input int nd, input int thr);
    int s, bs, bd, a, b;
    logic [31:0] w;
    bs = 0; bd = 0;
    for (int dd = 0; dd < nd; dd++) begin
      s = 0;
      for (int k = -h; k <= h; k++) begin
        a = lpix[y][cl(x + k)];
        b = rpix[y][cl(x + k - dd)];
        s += (a > b) ? a - b : b - a;
      end
      if (dd == 0 || s < bs) begin bs = s; bd = dd; end
    end
    w = '0;
    w[31]    = (x == HRES - 1 && y == VRES - 1);
    w[30]    = (bs > thr);
    w[29:16] = (bs > 16383) ? 14'h3FFF : 14'(bs);
    w[7:0]   = 8'(bd);
    return w;
  endfunction

  task automatic load_images();
    logic [31:0] r;
    for (int y = 0; y < VRES; y++)
      for (int x = 0; x < HRES; x++) begin
        r = $urandom(); lmem[y * HRES + x] = {r[31:8], 8'(lpix[y][x])};
        r = $urandom(); rmem[y * HRES + x] = {r[31:8], 8'(rpix[y][x])};
      end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en_ref"}, 32'(bus.en_ref), 32'd0);
    chk({tag, "_enb"}, 32'(bus.enb), 32'd0);
    chk({tag, "_addr_ref"}, bus.addr_ref, 32'd0);
    chk({tag, "_addrb"}, bus.addrb, 32'd0);
    chk({tag, "_din"}, bus.din_fifo, 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en_fifo), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Wait for done, then compare the frame's writes, timing and enable count
  task automatic finish_frame(input string tag, input int base, input int ebase, input int win,
                              input int ndc, input int thr, input bit timing);
    int t, n, per;
    t = 0;
    while (done !== 1'b1 && t < 30000) begin @(negedge clkb); t++; end
    @(negedge clkb);
    busy_rand = 1'b0;
    chk({tag, "_no_timeout"}, 32'(t < 30000), 32'd1);
    n = wq.size() - base;
    chk({tag, "_nwrites"}, 32'(n), 32'(NPIX));
    for (int i = 0; i < NPIX && i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), wq[base + i], model_word(i % HRES, i / HRES, win, ndc, thr));
    if (timing && n == NPIX) begin
      per = ndc * (2 * win + 3) + 1;
      for (int i = 1; i < NPIX; i++)
        chk($sformatf("%s_gap%0d", tag, i), 32'(wq_cyc[base + i] - wq_cyc[base + i - 1]), 32'(per));
      chk({tag, "_done_lat"}, 32'(done_cyc - wq_cyc[base + NPIX - 1]), 32'd1);
    end
    chk({tag, "_en_cycles"}, 32'(en_cnt - ebase), 32'(NPIX * ndc * (2 * win + 1)));
    chk({tag, "_we_zero"}, 32'(we_bad), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int win, input int nd, input int thr,
                           input bit rb, output int base);
    int ebase;
    repeat (2) @(negedge clkb);
    base = wq.size(); ebase = en_cnt;
    window = 3'(win); num_disp = 8'(nd); thresh = 16'(thr); busy_rand = rb;
    go = 1'b1;
    @(negedge clkb);
    go = 1'b0;
    chk({tag, "_first_en"}, 32'(bus.en_ref), 32'd1);
    chk({tag, "_first_addr_ref"}, bus.addr_ref, 32'd0);
    chk({tag, "_first_addrb"}, bus.addrb, 32'd0);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    window = 3'($urandom()); num_disp = 8'($urandom()); thresh = 16'($urandom());
    finish_frame(tag, base, ebase, win, eff_nd(nd), thr, !rb);
  endtask

  initial begin
    int base, ebase, t, wr_seen, unstable;
    logic [31:0] held;

    #3 reset = 1'b1;
    #2 chk_zero("rst_init");
    repeat (3) @(negedge clkb);
    reset = 1'b0;

    // Constant images: every word zero except eof on the last one
    for (int y = 0; y < VRES; y++)
      for (int x = 0; x < HRES; x++) begin lpix[y][x] = 16; rpix[y][x] = 16; end
    load_images();
    run_frame("const", 1, 4, 0, 1'b0, base);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("const_word%0d", i), wq[base + i], (i == NPIX - 1) ? 32'h8000_0000 : 32'h0);
    chk("const_done_high", 32'(done), 32'd1);
    @(posedge clkb); #3 reset = 1'b1;
    #1 chk_zero("rst_in_done");
    @(negedge clkb); reset = 1'b0;

    // Right image is the left shifted by three pixels
    for (int y = 0; y < VRES; y++)
      for (int x = 0; x < HRES; x++) begin lpix[y][x] = 10 * x; rpix[y][x] = 10 * cl(x + 3); end
    load_images();
    run_frame("shift", 1, 6, 100, 1'b0, base);
    chk("shift_x4_d", 32'(wq[base + 4][7:0]), 32'd3);
    chk("shift_x4_sad", 32'(wq[base + 4][29:16]), 32'd0);
    chk("shift_x5_d", 32'(wq[base + 5][7:0]), 32'd3);
    chk("shift_x5_sad", 32'(wq[base + 5][29:16]), 32'd0);

    // Single tap, single disparity: pixel period of four cycles
    run_frame("w0", 0, 1, 0, 1'b0, base);

    // Backpressure held at the first EMIT
    repeat (2) @(negedge clkb);
    base = wq.size(); ebase = en_cnt;
    busy_force = 1'b1;
    window = 3'd0; num_disp = 8'd1; thresh = 16'd50;
    go = 1'b1;
    @(negedge clkb);
    go = 1'b0;
    wr_seen = 0; unstable = 0;
    repeat (3) @(negedge clkb);
    held = bus.din_fifo;
    chk("busy_held_word", held, model_word(0, 0, 0, 1, 50));
    for (int i = 0; i < 20; i++) begin
      @(negedge clkb);
      if (bus.wr_en_fifo) wr_seen++;
      if (bus.din_fifo !== held) unstable++;
    end
    chk("busy_no_write", 32'(wr_seen), 32'd0);
    chk("busy_din_stable", 32'(unstable), 32'd0);
    @(posedge clkb); #2 busy_force = 1'b0;
    @(negedge clkb);
    chk("busy_release_wr", 32'(bus.wr_en_fifo), 32'd1);
    chk("busy_release_din", bus.din_fifo, held);
    finish_frame("busy", base, ebase, 0, 1, 50, 1'b0);

    // Right = left + 1: best SAD equals the tap count, tested against thresholds
    for (int y = 0; y < VRES; y++)
      for (int x = 0; x < HRES; x++) begin lpix[y][x] = 20 + 7 * x + y; rpix[y][x] = lpix[y][x] + 1; end
    load_images();
    run_frame("thr0", 2, 4, 0, 1'b0, base);
    for (int i = 0; i < NPIX; i += 5) begin
      chk($sformatf("thr0_inv%0d", i), 32'(wq[base + i][30]), 32'd1);
      chk($sformatf("thr0_sad%0d", i), 32'(wq[base + i][29:16]), 32'd5);
      chk($sformatf("thr0_d%0d", i), 32'(wq[base + i][7:0]), 32'd0);
    end
    run_frame("thr5", 2, 4, 5, 1'b0, base);
    for (int i = 0; i < NPIX; i += 5)
      chk($sformatf("thr5_inv%0d", i), 32'(wq[base + i][30]), 32'd0);

    // Reset during pixel 5, then a clean restart
    repeat (2) @(negedge clkb);
    base = wq.size();
    window = 3'd1; num_disp = 8'd3; thresh = 16'd0;
    go = 1'b1;
    @(negedge clkb);
    go = 1'b0;
    t = 0;
    while (wq.size() - base < 5 && t < 5000) begin @(negedge clkb); t++; end
    chk("rst_mid_reach_px5", 32'(t < 5000), 32'd1);
    repeat (3) @(negedge clkb);
    @(posedge clkb); #3 reset = 1'b1;
    #1 chk_zero("rst_mid");
    repeat (2) @(negedge clkb);
    reset = 1'b0;
    run_frame("restart", 1, 3, 0, 1'b0, base);

    // Randomised images and settings under random backpressure
    for (int f = 0; f < 5; f++) begin
      int win, nd;
      for (int y = 0; y < VRES; y++)
        for (int x = 0; x < HRES; x++) begin
          lpix[y][x] = $urandom_range(0, 255);
          rpix[y][x] = (f[0]) ? cl(lpix[y][x] + $urandom_range(0, 6) - 3) : $urandom_range(0, 255);
        end
      load_images();
      win = $urandom_range(0, 7);
      nd  = (f == 0) ? 0 : (f == 1) ? 255 : $urandom_range(1, MAX_DISP);
      run_frame($sformatf("rand%0d", f), win, nd, $urandom_range(0, 600), 1'b1, base);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
